// File: rtl/bcd_to_binary_seq_pkg.sv
// bcd_to_binary_seq_pkg: shared defaults, state encoding and counter width for the BCD-to-binary converter.
package bcd_to_binary_seq_pkg;
  localparam int NDIG_DEF = 11;
  localparam int BW_DEF = 36;
  localparam int CNT_W = 6;
  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] FINISH_ENC = 2'd2;
  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    FINISH = FINISH_ENC
  } state_t;
endpackage

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// bcd_digit_adjust: one reverse double-dabble cell, subtracts 3 from a digit that is 8 or more.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d[3] ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential reverse double-dabble BCD-to-binary converter.
// Optional input digit check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int BW = BW_DEF
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              ovf,
  output logic              err
);
  localparam int DW = 4*NDIG;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DW+BW-1:0] work, shifted;
  logic [DW-1:0] adj;
  assign shifted = work >> 1;
  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_adj
      bcd_digit_adjust u_adj (.d(shifted[BW+4*i +: 4]), .q(adj[4*i +: 4]));
    end
  endgenerate
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad, err_pend;
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) bad = bad | (bcd_in[4*k +: 4] > 4'd9);
  end
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bin_out <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      work <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err <= 1'b0;
      err_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          work <= {bcd_in, {BW{1'b0}}};
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          // a bad digit clears the work register so FINISH reports zero with no overflow
          err_pend <= bad;
          if (bad) work <= '0;
`endif
        end
        SHIFT: begin
          work <= {adj, shifted[BW-1:0]};
          cnt <= cnt + 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          state <= (err_pend || cnt == CNT_W'(BW-1)) ? FINISH : SHIFT;
`else
          state <= (cnt == CNT_W'(BW-1)) ? FINISH : SHIFT;
`endif
        end
        FINISH: begin
          bin_out <= work[BW-1:0];
          ovf <= |work[DW+BW-1:BW];
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err <= err_pend;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed and randomized checks of bcd_to_binary_seq against a decimal arithmetic model.
module tb_bcd_to_binary_seq;
  localparam int NDIG = 11;
  localparam int BW = 36;
  localparam longint LIM = 64'd68719476736;
  logic Clk, reset_n, start, busy, done, ovf, err;
  logic [4*NDIG-1:0] bcd_in;
  logic [BW-1:0] bin_out;
  int checks = 0;
  int errors = 0;

  bcd_to_binary_seq #(.NDIG(NDIG), .BW(BW)) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .ovf(ovf), .err(err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic longint dec_val(input logic [4*NDIG-1:0] b);
    longint v = 0;
    for (int i = NDIG-1; i >= 0; i--) v = v*10 + longint'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input longint v);
    logic [4*NDIG-1:0] b;
    longint t = v;
    for (int i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy) bc++;
      @(posedge Clk);
      #1 n++;
    end
  endtask

  task automatic accept(input logic [4*NDIG-1:0] b);
    @(negedge Clk);
    bcd_in = b;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    bcd_in = ~b;
  endtask

  task automatic check_result(input string tag, input logic [4*NDIG-1:0] b);
    longint v = dec_val(b);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_bin"}, bin_out, v[BW-1:0]);
    chk({tag, "_ovf"}, ovf, v >= LIM);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic conv(input logic [4*NDIG-1:0] b, input string tag);
    int n, bc;
    accept(b);
    wait_done(n, bc);
    chk({tag, "_lat"}, n, 37);
    chk({tag, "_busy"}, bc, 37);
    check_result(tag, b);
  endtask

  initial begin
    logic [4*NDIG-1:0] a, b;
    logic [BW-1:0] held;
    int n, bc, seen;
    reset_n = 1'b0;
    start = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bin", bin_out, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", err, 1'b0);
    reset_n = 1'b1;
    conv(44'h0, "zero");
    conv(44'h00000012345, "d12345");
    chk("d12345_const", bin_out, 36'h000003039);
    conv(44'h68719476735, "max");
    chk("max_const", bin_out, 36'hFFFFFFFFF);
    conv(44'h68719476736, "lim");
    chk("lim_ovf_const", {ovf, bin_out}, {1'b1, 36'h0});
    conv(44'h99999999999, "nines");
    chk("nines_ovf_const", ovf, 1'b1);
    // invalid digit 3
    accept(44'h0000000A000);
    wait_done(n, bc);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    chk("bad_lat", n, 2);
    chk("bad_err", err, 1'b1);
    chk("bad_bin", bin_out, 0);
    chk("bad_ovf", ovf, 1'b0);
`else
    chk("bad_lat", n, 37);
    chk("bad_err", err, 1'b0);
`endif
    chk("bad_done", done, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0)
        for (int i = 0; i < NDIG; i++) b[4*i +: 4] = 4'($urandom_range(9));
      else
        b = to_bcd((longint'($urandom) << 5) ^ longint'($urandom_range(31)));
      conv(b, $sformatf("rnd%0d", k));
    end
    // start pulsed mid-conversion must be ignored
    held = bin_out;
    a = 44'h00987654321;
    accept(a);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    bcd_in = 44'h00000000007;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    chk("mid_hold_bin", bin_out, held);
    chk("mid_busy", busy, 1'b1);
    wait_done(n, bc);
    chk("mid_lat", 10 + n, 37);
    check_result("mid", a);
    // start held through the done cycle starts a back-to-back conversion
    b = 44'h00055555555;
    bcd_in = b;
    start = 1'b1;
    chk("b2b_idle_busy", busy, 1'b0);
    @(posedge Clk);
    #1 start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    wait_done(n, bc);
    chk("b2b_lat", n, 37);
    check_result("b2b", b);
    // reset mid-conversion aborts
    accept(44'h12345678901);
    repeat (19) @(posedge Clk);
    @(negedge Clk);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_bin", bin_out, 0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_err", err, 1'b0);
    @(negedge Clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (45) begin
      @(posedge Clk);
      #1 if (done) seen++;
    end
    chk("arst_no_done", seen, 0);
    conv(44'h00000000042, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
